branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter BTB_ENTRIES, default 16, giving the number of direct-mapped BTB entries (power of two, 2..256); IW = log2(BTB_ENTRIES).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port fetch_pc  input  32  PC currently held by the fetch stage, looked up every cycle.
REQ-005 The block SHALL have port next_pc  output  32  predicted successor of fetch_pc.
REQ-006 The block SHALL have port next_jump  output  1  1 = next_pc is a predicted-taken target.
REQ-007 The block SHALL have port upd_valid  input  1  resolved control-transfer report from EXE this cycle.
REQ-008 The block SHALL have port upd_pc  input  32  PC of the resolved instruction.
REQ-009 The block SHALL have port upd_target  input  32  resolved target (jb_pc).
REQ-010 The block SHALL have port upd_taken  input  1  actual direction.
REQ-011 The block SHALL have port upd_is_jump  input  1  1 = unconditional jump (JAL/JALR), 0 = conditional branch.

Function
REQ-012 Each entry SHALL hold: valid(1), tag(32-IW-2 = fetch_pc[31:IW+2]), target(32), is_jump(1), ctr(2, saturating).
REQ-013 Lookup SHALL be combinational: idx = fetch_pc[IW+1:2]; hit = valid[idx] && tag[idx] == fetch_pc[31:IW+2]; fetch_pc[1:0] ignored.
REQ-014 next_jump SHALL equal hit && (is_jump[idx] || ctr[idx][1]).
REQ-015 next_pc SHALL equal target[idx] when next_jump=1, else fetch_pc + 4 modulo 2^32 (0xFFFFFFFC + 4 -> 0x00000000).
REQ-016 Updates SHALL take effect at the rising edge ending the cycle in which upd_valid=1; upd_* ignored when upd_valid=0.
REQ-017 Update hit (valid and tag match at upd index): ctr +1 saturating at 2'b11 if upd_taken, -1 saturating at 2'b00 otherwise; target and is_jump overwritten only when upd_taken=1.
REQ-018 Update miss with upd_taken=1: entry allocated/overwritten: valid=1, tag/target/is_jump from upd_*, ctr=2'b11 if upd_is_jump else 2'b10.
REQ-019 Update miss with upd_taken=0: no table change.
REQ-020 Entry with is_jump=1 SHALL predict taken regardless of ctr.
REQ-021 Lookup and update to the same index in the same cycle: lookup SHALL return pre-update contents (no bypass); new contents visible from next cycle.
REQ-022 Aliasing entries (same idx, different tag) SHALL be replaced only per REQ-018; no partial tag match.
REQ-023 Block SHALL have no stall/backpressure; outputs valid every cycle after reset deassertion.

Reset
REQ-024 On rst=0 (asynchronous), all valid bits SHALL clear and all ctr SHALL be 2'b01; target/tag/is_jump need not be reset.
REQ-025 During and after reset, next_jump SHALL be 0 and next_pc SHALL equal fetch_pc + 4.
REQ-026 Reset asserted mid-update SHALL discard that update; first update accepted at first rising edge with rst=1.

Verification
REQ-027 After reset, fetch_pc=0x00000100 -> next_pc=0x00000104, next_jump=0.
REQ-028 Update upd_pc=0x100, taken=1, is_jump=0, target=0x200; next cycle fetch_pc=0x100 -> next_pc=0x200, next_jump=1 (ctr=10); then one not-taken update -> ctr=01, next_pc=0x104, next_jump=0.
REQ-029 Four taken updates on a hit -> ctr saturates 11; three not-taken -> ctr 00, prediction not-taken; further not-taken keeps 00.
REQ-030 JAL at 0x40 target 0x80 allocated; five not-taken updates on same entry -> still next_pc=0x80, next_jump=1.
REQ-031 BTB_ENTRIES=16: allocate 0x100 (target 0x300) then taken update 0x140 (same idx 0, target 0x500) -> lookup 0x100 misses (0x104), 0x140 hits (0x500); same-cycle lookup/update of 0x140 returns old result; fetch_pc=0xFFFFFFFC miss -> next_pc=0x00000000.
REQ-032 Assert rst=0 asynchronously between edges with a populated table -> next_jump drops to 0 immediately, all lookups miss after release.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on fetch_pc; resolved EXE reports train the table at the rising edge.
module branch_predictor #(
   parameter int BTB_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc,
   output logic [31:0] next_pc,
   output logic        next_jump,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   input  logic        upd_is_jump
);

   localparam int IW = $clog2(BTB_ENTRIES);
   localparam int TW = 30 - IW;

   typedef logic [IW-1:0] idx_t;
   typedef logic [TW-1:0] tag_t;

   logic [BTB_ENTRIES-1:0] valid_q;
   logic [1:0]             ctr_q    [BTB_ENTRIES];
   tag_t                   tag_q    [BTB_ENTRIES];
   logic [31:0]            target_q [BTB_ENTRIES];
   logic                   isJump_q [BTB_ENTRIES];

   idx_t       fetchIdx;
   tag_t       fetchTag;
   logic       fetchHit;
   idx_t       updIdx;
   tag_t       updTag;
   logic       updHit;
   logic [1:0] updCtr_d;
   logic       unusedUpdLsb;

   assign fetchIdx     = fetch_pc[IW+1:2];
   assign fetchTag     = fetch_pc[31:IW+2];
   assign updIdx       = upd_pc[IW+1:2];
   assign updTag       = upd_pc[31:IW+2];
   assign unusedUpdLsb = ^upd_pc[1:0];

   assign fetchHit  = valid_q[fetchIdx] && (tag_q[fetchIdx] == fetchTag);
   assign next_jump = fetchHit && (isJump_q[fetchIdx] || ctr_q[fetchIdx][1]);
   assign next_pc   = next_jump ? target_q[fetchIdx] : fetch_pc + 32'd4;

   assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);

   // Hits step the counter with saturation; taken misses allocate biased-taken.
   always_comb begin
      updCtr_d = ctr_q[updIdx];
      if (updHit) begin
         if (upd_taken && ctr_q[updIdx] != 2'b11) begin
            updCtr_d = ctr_q[updIdx] + 2'd1;
         end else if (!upd_taken && ctr_q[updIdx] != 2'b00) begin
            updCtr_d = ctr_q[updIdx] - 2'd1;
         end
      end else begin
         updCtr_d = upd_is_jump ? 2'b11 : 2'b10;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            ctr_q[i] <= 2'b01;
         end
      end else if (upd_valid && (updHit || upd_taken)) begin
         valid_q[updIdx] <= 1'b1;
         ctr_q[updIdx]   <= updCtr_d;
      end
   end

   // Payload is not reset; a taken report rewrites it (tag is unchanged on a hit).
   always_ff @(posedge clk) begin
      if (rst && upd_valid && upd_taken) begin
         tag_q[updIdx]    <= updTag;
         target_q[updIdx] <= upd_target;
         isJump_q[updIdx] <= upd_is_jump;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised and directed bench for branch_predictor; a BTB reference model feeds
// a scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_branch_predictor;

   localparam int N  = 16;
   localparam int IW = 4;

   logic        clk;
   logic        rst;
   logic [31:0] fetch_pc;
   logic [31:0] next_pc;
   logic        next_jump;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        upd_is_jump;

   branch_predictor #(.BTB_ENTRIES(N)) dut (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .next_pc(next_pc), .next_jump(next_jump),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken), .upd_is_jump(upd_is_jump)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        jump;
   } exp_t;

   exp_t sbQ[$];
   int   total = 0;
   int   bad   = 0;

   // Reference table: one record per slot, indexed by (pc / 4) mod N.
   bit          mValid  [N];
   int unsigned mTag    [N];
   logic [31:0] mTarget [N];
   bit          mJump   [N];
   int          mCtr    [N];

   function automatic void modelReset();
      for (int i = 0; i < N; i++) begin
         mValid[i] = 0;
         mCtr[i]   = 1;
      end
   endfunction

   function automatic bit modelHit(logic [31:0] pc);
      int slot = int'((pc / 4) % N);
      return mValid[slot] && (mTag[slot] == pc / (4 * N));
   endfunction

   function automatic exp_t modelPredict(string nm, logic [31:0] pc);
      exp_t e;
      int   slot = int'((pc / 4) % N);
      e.name = nm;
      e.jump = modelHit(pc) && (mJump[slot] || mCtr[slot] >= 2);
      e.pc   = e.jump ? mTarget[slot] : pc + 32'd4;
      return e;
   endfunction

   function automatic void modelUpdate(logic [31:0] pc, logic [31:0] tgt, logic tk, logic jp);
      int slot = int'((pc / 4) % N);
      if (modelHit(pc)) begin
         if (tk) begin
            mCtr[slot]    = (mCtr[slot] < 3) ? mCtr[slot] + 1 : 3;
            mTarget[slot] = tgt;
            mJump[slot]   = jp;
         end else begin
            mCtr[slot] = (mCtr[slot] > 0) ? mCtr[slot] - 1 : 0;
         end
      end else if (tk) begin
         mValid[slot]  = 1;
         mTag[slot]    = pc / (4 * N);
         mTarget[slot] = tgt;
         mJump[slot]   = jp;
         mCtr[slot]    = jp ? 3 : 2;
      end
   endfunction

   // One cycle of stimulus: predict from the pre-update model, then train it.
   task automatic applyStimulus(input string nm, input logic [31:0] pc, input logic uv,
                                input logic [31:0] upc, input logic [31:0] tgt,
                                input logic tk, input logic jp);
      @(posedge clk);
      #1;
      fetch_pc    = pc;
      upd_valid   = uv;
      upd_pc      = upc;
      upd_target  = tgt;
      upd_taken   = tk;
      upd_is_jump = jp;
      sbQ.push_back(modelPredict(nm, pc));
      if (uv) modelUpdate(upc, tgt, tk, jp);
   endtask

   task automatic lookup(input string nm, input logic [31:0] pc);
      applyStimulus(nm, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic train(input string nm, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic tk, input logic jp);
      applyStimulus(nm, pc, 1'b1, pc, tgt, tk, jp);
   endtask

   // Reset dropped between edges while an update is pending; the update must be lost.
   task automatic pulseReset(input logic [31:0] pc);
      @(posedge clk);
      #1;
      fetch_pc    = pc;
      upd_valid   = 1'b1;
      upd_pc      = pc;
      upd_target  = 32'hDEAD_0000;
      upd_taken   = 1'b1;
      upd_is_jump = 1'b1;
      #1;
      rst = 1'b0;
      modelReset();
      sbQ.push_back(modelPredict("async_reset", pc));
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      rst       = 1'b1;
   endtask

   task automatic checkOutput(input exp_t e);
      total++;
      if (next_pc !== e.pc || next_jump !== e.jump) begin
         bad++;
         $display("[TB] FAIL %s: got next_pc=%h next_jump=%b, expected next_pc=%h next_jump=%b",
                  e.name, next_pc, next_jump, e.pc, e.jump);
      end
   endtask

   always @(negedge clk) begin
      if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
   end

   initial begin
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        uv;
      int          waitCycles;

      rst         = 1'b0;
      fetch_pc    = 32'h0000_0100;
      upd_valid   = 1'b0;
      upd_pc      = 32'h0;
      upd_target  = 32'h0;
      upd_taken   = 1'b0;
      upd_is_jump = 1'b0;
      modelReset();
      sbQ.push_back(modelPredict("in_reset", 32'h0000_0100));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      lookup("after_reset", 32'h0000_0100);
      train("alloc_100", 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0);
      lookup("hit_ctr10", 32'h0000_0100);
      train("nt_100", 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
      lookup("ctr01_nt", 32'h0000_0100);
      for (int i = 0; i < 4; i++) train("sat_up", 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0);
      lookup("ctr11", 32'h0000_0100);
      for (int i = 0; i < 3; i++) train("sat_dn", 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
      lookup("ctr00", 32'h0000_0100);
      train("nt_floor", 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
      lookup("ctr00_hold", 32'h0000_0100);

      train("jal_alloc", 32'h0000_0040, 32'h0000_0080, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) train("jal_nt", 32'h0000_0040, 32'h0000_0080, 1'b0, 1'b1);
      lookup("jal_still_taken", 32'h0000_0040);

      train("alloc_100_b", 32'h0000_0100, 32'h0000_0300, 1'b1, 1'b0);
      lookup("hit_100_300", 32'h0000_0100);
      train("alias_140", 32'h0000_0140, 32'h0000_0500, 1'b1, 1'b0);
      lookup("alias_miss_100", 32'h0000_0100);
      lookup("alias_hit_140", 32'h0000_0140);
      applyStimulus("same_cycle", 32'h0000_0140, 1'b1, 32'h0000_0140, 32'h0000_0600, 1'b1, 1'b1);
      lookup("after_same_cycle", 32'h0000_0140);
      lookup("wrap_pc", 32'hFFFF_FFFC);
      lookup("low_bits_ignored", 32'h0000_0143);

      for (int i = 0; i < 400; i++) begin
         pc  = {($urandom_range(0, 3) == 0) ? 24'hFFFF_FF : 24'h0, 6'($urandom_range(0, 63)), 2'b00};
         tgt = $urandom & 32'hFFFF_FFFC;
         uv  = 1'($urandom_range(0, 2) != 0);
         applyStimulus("random", 32'($urandom_range(0, 1)) == 0 ? pc : {pc[31:8], 8'($urandom)},
                       uv, pc, tgt, 1'($urandom), 1'($urandom_range(0, 4) == 0));
      end

      train("pre_rst_a", 32'h0000_0040, 32'h0000_0080, 1'b1, 1'b1);
      train("pre_rst_b", 32'h0000_0100, 32'h0000_0300, 1'b1, 1'b1);
      lookup("pre_rst_hit", 32'h0000_0040);
      pulseReset(32'h0000_0040);
      lookup("post_rst_a", 32'h0000_0040);
      lookup("post_rst_b", 32'h0000_0100);
      train("first_after_rst", 32'h0000_0100, 32'h0000_0700, 1'b1, 1'b0);
      lookup("alloc_after_rst", 32'h0000_0100);

      waitCycles = 0;
      while (sbQ.size() > 0 && waitCycles < 20) begin
         @(posedge clk);
         waitCycles++;
      end
      if (sbQ.size() > 0) begin
         bad++;
         $display("[TB] FAIL drain: %0d expected results never checked, expected 0", sbQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
